// File: rtl/nv_nvdla_hls_sat_arb.sv
// rtl/nv_nvdla_hls_sat_arb.sv - two-requester round-robin arbiter sharing one signed saturation stage
module nv_nvdla_hls_sat_arb #(
  parameter int IN_WIDTH  = 49,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 req0_pvld,
  output logic                 req0_prdy,
  input  logic [IN_WIDTH-1:0]  req0_pd,
  input  logic                 req1_pvld,
  output logic                 req1_prdy,
  input  logic [IN_WIDTH-1:0]  req1_pd,
  output logic                 out_pvld,
  input  logic                 out_prdy,
  output logic [OUT_WIDTH-1:0] out_pd,
  output logic                 out_src,
  output logic                 out_sat,
  input  logic                 sat_cnt_clr,
  output logic [CNT_WIDTH-1:0] sat_cnt0,
  output logic [CNT_WIDTH-1:0] sat_cnt1
);

  localparam int HI_WIDTH = IN_WIDTH - OUT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 last_gnt;
  logic                 pipe_rdy;
  logic                 any_vld;
  logic                 gnt;
  logic                 accept;
  logic [IN_WIDTH-1:0]  sel_pd;
  logic                 sign;
  logic [HI_WIDTH-1:0]  hi_bits;
  logic                 sat;
  logic [OUT_WIDTH-1:0] result;

  assign pipe_rdy = ~out_pvld | out_prdy;
  assign any_vld  = req0_pvld | req1_pvld;

  // Contention goes to whoever did not win last; otherwise the lone requester wins.
  assign gnt = (req0_pvld & req1_pvld) ? ~last_gnt : req1_pvld;

  // Gating with reset keeps both prdy low while the block is held in reset.
  assign accept    = nvdla_core_rstn & pipe_rdy & any_vld;
  assign req0_prdy = accept & ~gnt;
  assign req1_prdy = accept & gnt;

  assign sel_pd  = gnt ? req1_pd : req0_pd;
  assign sign    = sel_pd[IN_WIDTH-1];
  assign hi_bits = sel_pd[IN_WIDTH-2:OUT_WIDTH-1];
  assign sat     = (hi_bits != {HI_WIDTH{sign}});

  always_comb begin
    result = sel_pd[OUT_WIDTH-1:0];
    if (sat) begin
      result = {sign, {(OUT_WIDTH-1){~sign}}};
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      last_gnt <= 1'b1;
      out_pvld <= 1'b0;
      out_pd   <= '0;
      out_src  <= 1'b0;
      out_sat  <= 1'b0;
    end else begin
      if (accept) begin
        last_gnt <= gnt;
        out_pvld <= 1'b1;
        out_pd   <= result;
        out_src  <= gnt;
        out_sat  <= sat;
      end else if (out_prdy) begin
        out_pvld <= 1'b0;
      end
    end
  end

  // Event counters stick at all-ones; a clear drops any same-cycle event.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sat_cnt0 <= '0;
      sat_cnt1 <= '0;
    end else if (sat_cnt_clr) begin
      sat_cnt0 <= '0;
      sat_cnt1 <= '0;
    end else if (accept && sat) begin
      if (!gnt && sat_cnt0 != CNT_MAX) begin
        sat_cnt0 <= sat_cnt0 + CNT_ONE;
      end
      if (gnt && sat_cnt1 != CNT_MAX) begin
        sat_cnt1 <= sat_cnt1 + CNT_ONE;
      end
    end
  end

endmodule
